// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions: default trellis sizes, traceback FSM
// states and the address-width helper used by every traceback file.
package viterbi_pkg;

  localparam int ST_W_DEF  = 8;
  localparam int DEPTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    TR_REQ,
    TR_WAIT,
    EMIT
  } tbc_state_e;

  // Keeps column pointers at least one bit wide for degenerate DEPTH = 1.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/traceback_ctrl_if.sv
// Handshake and survivor-memory signals between the traceback controller
// (master) and the ACS unit, survivor memory and bit sink (slave).
interface traceback_ctrl_if #(
  parameter int ST_W  = viterbi_pkg::ST_W_DEF,
  parameter int DEPTH = viterbi_pkg::DEPTH_DEF
);
  localparam int AW = viterbi_pkg::addr_w(DEPTH);

  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic            en_acs;
  logic [AW-1:0]   wr_addr;
  logic [ST_W-1:0] best_st;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [ST_W-1:0] rd_st;
  logic [ST_W-1:0] rd_prv_st;
  logic            out_valid;
  logic            out_bit;
  logic            out_last;
  logic            out_ready;

  modport master (
    input  in_valid, in_last, best_st, rd_prv_st, out_ready,
    output in_ready, en_acs, wr_addr, rd_en, rd_addr, rd_st,
           out_valid, out_bit, out_last
  );

  modport slave (
    output in_valid, in_last, best_st, rd_prv_st, out_ready,
    input  in_ready, en_acs, wr_addr, rd_en, rd_addr, rd_st,
           out_valid, out_bit, out_last
  );

endinterface

// File: rtl/tb_bit_buf.sv
// Decoded-bit buffer: filled backwards during traceback, read forwards on emit.
// Contents are never reset; every location is rewritten before it is read.
module tb_bit_buf #(
  parameter int DEPTH = viterbi_pkg::DEPTH_DEF,
  parameter int AW    = viterbi_pkg::addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read so out_bit follows the emit index in the same cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/traceback_ctrl.sv
// Viterbi traceback controller: counts ACS steps into survivor columns, walks
// the survivor path backwards from best_st, then emits the bits in order.
module traceback_ctrl
  import viterbi_pkg::*;
#(
  parameter int ST_W  = ST_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  traceback_ctrl_if.master bus,
  output logic             busy
);

  localparam int          AW     = addr_w(DEPTH);
  localparam logic [AW:0] LAST_N = (AW+1)'(DEPTH - 1);

  tbc_state_e      state_reg, state_next;
  logic [AW:0]     n_reg, n_next;
  logic [AW:0]     len_reg, len_next;
  logic [AW-1:0]   c_reg, c_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic [ST_W-1:0] st_reg, st_next;
  logic            first_reg, first_next;

  logic            ready_c;
  logic            rd_en_c;
  logic [AW-1:0]   rd_addr_c;
  logic [ST_W-1:0] rd_st_c;
  logic            valid_c;
  logic            bit_c;
  logic            last_c;
  logic            buf_we;
  logic            buf_rd;
  logic [ST_W-1:0] cur_st;
  logic [AW:0]     last_idx;

  tb_bit_buf #(.DEPTH(DEPTH), .AW(AW)) u_bit_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (c_reg),
    .wdata (cur_st[0]),
    .raddr (idx_reg),
    .rdata (buf_rd)
  );

  // best_st is only valid the cycle after the final column write.
  assign cur_st   = first_reg ? bus.best_st : st_reg;
  assign last_idx = len_reg - 1'b1;

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    len_next   = len_reg;
    c_next     = c_reg;
    idx_next   = idx_reg;
    st_next    = st_reg;
    first_next = first_reg;
    ready_c    = 1'b0;
    rd_en_c    = 1'b0;
    rd_addr_c  = '0;
    rd_st_c    = '0;
    valid_c    = 1'b0;
    bit_c      = 1'b0;
    last_c     = 1'b0;
    buf_we     = 1'b0;

    case (state_reg)
      IDLE, FILL: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          n_next     = n_reg + 1'b1;
          state_next = FILL;
          if (bus.in_last || n_reg == LAST_N) begin
            state_next = TR_REQ;
            len_next   = n_reg + 1'b1;
            c_next     = n_reg[AW-1:0];
            first_next = 1'b1;
          end
        end
      end
      TR_REQ: begin
        rd_en_c    = 1'b1;
        rd_addr_c  = c_reg;
        rd_st_c    = cur_st;
        buf_we     = 1'b1;
        st_next    = cur_st;
        first_next = 1'b0;
        state_next = TR_WAIT;
      end
      TR_WAIT: begin
        st_next = bus.rd_prv_st;
        if (c_reg == '0) begin
          state_next = EMIT;
          idx_next   = '0;
        end else begin
          c_next     = c_reg - 1'b1;
          state_next = TR_REQ;
        end
      end
      EMIT: begin
        valid_c = 1'b1;
        bit_c   = buf_rd;
        last_c  = ({1'b0, idx_reg} == last_idx);
        if (bus.out_ready) begin
          if (last_c) begin
            state_next = IDLE;
            idx_next   = '0;
            n_next     = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      len_reg   <= '0;
      c_reg     <= '0;
      idx_reg   <= '0;
      st_reg    <= '0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      len_reg   <= len_next;
      c_reg     <= c_next;
      idx_reg   <= idx_next;
      st_reg    <= st_next;
      first_reg <= first_next;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.en_acs    = bus.in_valid & ready_c;
  assign bus.wr_addr   = n_reg[AW-1:0];
  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr   = rd_addr_c;
  assign bus.rd_st     = rd_st_c;
  assign bus.out_valid = valid_c;
  assign bus.out_bit   = bit_c;
  assign bus.out_last  = last_c;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_traceback_ctrl.sv
// Randomised scoreboard bench for traceback_ctrl with a behavioural survivor
// memory and a path-walking reference model.
module tb_traceback_ctrl;
  import viterbi_pkg::*;

  localparam int ST_W  = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  traceback_ctrl_if #(.ST_W(ST_W), .DEPTH(DEPTH)) bus ();

  traceback_ctrl #(.ST_W(ST_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int passes      = 0;
  int frames_done = 0;
  int hold_cnt    = 0;

  int wr_q[$];
  int rd_q[$];
  int out_q[$];
  int lat_q[$];

  // Survivor memory: predecessor shifts in the column's survivor bit at the top.
  logic            key [DEPTH];
  logic [ST_W-1:0] prv_q = '0;

  always @(posedge clk) begin
    if (bus.rd_en) prv_q <= {key[bus.rd_addr], bus.rd_st[ST_W-1:1]};
  end
  assign bus.rd_prv_st = prv_q;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got nothing, required an event", name);
  endtask

  // Reference: walk the path from best back to column 0, emit LSBs forwards.
  task automatic push_model(input int n, input logic [ST_W-1:0] best);
    logic [ST_W-1:0] s [DEPTH];
    s[n-1] = best;
    for (int c = n - 1; c > 0; c--) s[c-1] = {key[c], s[c][ST_W-1:1]};
    for (int c = n - 1; c >= 0; c--) rd_q.push_back(c * 256 + int'(s[c]));
    for (int c = 0; c < n; c++) out_q.push_back(int'(s[c][0]) * 2 + ((c == n - 1) ? 1 : 0));
    lat_q.push_back(2 * n);
  endtask

  task automatic randomize_key();
    for (int i = 0; i < DEPTH; i++) key[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic feed(input int n, input bit use_last, input logic [ST_W-1:0] best);
    bus.best_st = best;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_last  = use_last && (i == n - 1);
      wr_q.push_back(i);
      @(negedge clk);
      check("in_ready_fill", int'(bus.in_ready), 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic finish_frame(input int n);
    int target;
    int cyc;
    target = frames_done + 1;
    cyc    = 0;
    @(negedge clk);
    check("in_ready_after_last", int'(bus.in_ready), 0);
    check("wr_addr_hold", int'(bus.wr_addr), n % DEPTH);
    @(posedge clk); #1;
    while (frames_done < target && cyc < 1000) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_last  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (frames_done < target) fail_now("frame_timeout");
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_cnt > 0) begin
        bus.out_ready = 1'b0;
        if (bus.out_valid) hold_cnt--;
      end else begin
        bus.out_ready = ($urandom_range(0, 9) < 6);
      end
    end
  end

  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_bit   = 1'b0;
  logic prev_last  = 1'b0;
  int   tr_cycles  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
      tr_cycles  = 0;
    end else begin
      if (bus.en_acs) begin
        if (wr_q.size() == 0) fail_now("unexpected_en_acs");
        else check("wr_addr", int'(bus.wr_addr), wr_q.pop_front());
      end
      if (bus.rd_en) begin
        if (rd_q.size() == 0) fail_now("unexpected_rd_en");
        else check("rd_addr_st", int'(bus.rd_addr) * 256 + int'(bus.rd_st), rd_q.pop_front());
      end
      if (bus.in_ready) tr_cycles = 0;
      else if (busy && !bus.out_valid) tr_cycles++;
      if (bus.out_valid && !prev_valid) begin
        if (lat_q.size() == 0) fail_now("unexpected_emit");
        else check("traceback_cycles", tr_cycles, lat_q.pop_front());
        tr_cycles = 0;
      end
      if (prev_valid && !prev_ready) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_bit_last", int'({bus.out_bit, bus.out_last}), int'({prev_bit, prev_last}));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (out_q.size() == 0) fail_now("unexpected_out");
        else check("out_bit_last", int'({bus.out_bit, bus.out_last}), out_q.pop_front());
        if (bus.out_last) frames_done++;
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_bit   = bus.out_bit;
      prev_last  = bus.out_last;
    end
  end

  initial begin
    int          d_st [5];
    int          d_bit [5];
    int          n;
    bit          use_last;
    bit          found;
    logic [ST_W-1:0] b;

    d_st  = '{'h16, 'h0B, 'h05, 'h02, 'h01};
    d_bit = '{1, 0, 1, 1, 0};
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.best_st  = '0;
    for (int i = 0; i < DEPTH; i++) key[i] = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_en_acs", int'(bus.en_acs), 0);
    check("rst_rd_en", int'(bus.rd_en), 0);
    check("rst_rd_addr", int'(bus.rd_addr), 0);
    check("rst_rd_st", int'(bus.rd_st), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_bit_last", int'({bus.out_bit, bus.out_last}), 0);
    check("rst_wr_addr", int'(bus.wr_addr), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed 5-step frame against hand-derived constants, with a 3-cycle sink stall.
    for (int i = 0; i < 5; i++) begin
      rd_q.push_back((4 - i) * 256 + d_st[i]);
      out_q.push_back(d_bit[i] * 2 + ((i == 4) ? 1 : 0));
    end
    lat_q.push_back(10);
    hold_cnt = 3;
    feed(5, 1'b1, 8'h16);
    finish_frame(5);

    // Full-depth frame with no in_last.
    randomize_key();
    b = 8'($urandom);
    push_model(DEPTH, b);
    feed(DEPTH, 1'b0, b);
    finish_frame(DEPTH);

    repeat (10) begin
      randomize_key();
      n        = $urandom_range(1, DEPTH);
      use_last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      b        = 8'($urandom);
      push_model(n, b);
      feed(n, use_last, b);
      finish_frame(n);
    end

    // Reset during TR_WAIT of a 10-step frame.
    randomize_key();
    b = 8'($urandom);
    push_model(10, b);
    feed(10, 1'b1, b);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (busy && !bus.in_ready && !bus.rd_en && !bus.out_valid) found = 1'b1;
    end
    if (!found) fail_now("tr_wait_not_reached");
    #2 rst = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_rd_en", int'(bus.rd_en), 0);
    check("arst_out_valid", int'(bus.out_valid), 0);
    rd_q.delete();
    out_q.delete();
    lat_q.delete();
    wr_q.delete();
    @(negedge clk);
    check("arst_busy_next", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    randomize_key();
    b = 8'($urandom);
    push_model(1, b);
    feed(1, 1'b1, b);
    finish_frame(1);

    repeat (3) @(posedge clk);
    check("end_rd_q_empty", rd_q.size(), 0);
    check("end_out_q_empty", out_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
